// File: rtl/adam_axil_to_mem_pkg.sv
// Shared types for the AXI-Lite to memory request bridge.
// FSM encoding and AXI response codes.
package adam_axil_to_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    B_RESP,
    R_RESP
  } state_t;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic resp_t err2resp(
    input logic err
  );
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/adam_axil_if.sv
// AXI-Lite bus bundle with master and slave views.
// Widths follow the instance parameters.
interface adam_axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport slv (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );

  modport mst (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

endinterface

// File: rtl/adam_axil_to_mem.sv
// AXI-Lite slave serialising reads and writes into
// one req/gnt memory transaction at a time.
module adam_axil_to_mem
  import adam_axil_to_mem_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  adam_axil_if.slv              slv,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [STRB_WIDTH-1:0] mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  localparam addr_t LOW_MASK = addr_t'(STRB_WIDTH - 1);

  state_t state;
  state_t state_nx;
  logic   live;
  logic   ptr_wr;
  logic   wr_ok;
  logic   rd_ok;
  logic   pick_wr;
  logic   take_wr;
  logic   take_rd;
  resp_t  b_resp;
  resp_t  r_resp;
  data_t  r_data;
  logic   unused;

  assign unused = ^{slv.aw_prot, slv.ar_prot};

  assign wr_ok   = slv.aw_valid & slv.w_valid;
  assign rd_ok   = slv.ar_valid;
  assign pick_wr = wr_ok & (ptr_wr | ~rd_ok);
  // live keeps every ready low while reset is held
  assign take_wr = live & (state == IDLE) & pick_wr;
  assign take_rd = live & (state == IDLE) & rd_ok & ~pick_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take_wr)      state_nx = WR_REQ;
        else if (take_rd) state_nx = RD_REQ;
      end
      WR_REQ:  if (mem_gnt)     state_nx = B_RESP;
      RD_REQ:  if (mem_gnt)     state_nx = RD_WAIT;
      RD_WAIT: if (mem_rvalid)  state_nx = R_RESP;
      B_RESP:  if (slv.b_ready) state_nx = IDLE;
      R_RESP:  if (slv.r_ready) state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_comb begin
    slv.aw_ready = take_wr;
    slv.w_ready  = take_wr;
    slv.ar_ready = take_rd;
    slv.b_valid  = (state == B_RESP);
    slv.r_valid  = (state == R_RESP);
    slv.b_resp   = b_resp;
    slv.r_resp   = r_resp;
    slv.r_data   = r_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_wr    <= 1'b1;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      b_resp    <= RESP_OKAY;
      r_resp    <= RESP_OKAY;
      r_data    <= '0;
    end else begin
      if (take_wr) begin
        ptr_wr    <= 1'b0;
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= slv.aw_addr & ~LOW_MASK;
        mem_be    <= slv.w_strb;
        mem_wdata <= slv.w_data;
      end else if (take_rd) begin
        ptr_wr   <= 1'b1;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= slv.ar_addr & ~LOW_MASK;
        mem_be   <= '1;
      end else if (mem_req && mem_gnt) begin
        mem_req <= 1'b0;
        if (mem_we) b_resp <= err2resp(mem_err);
      end
      if (state == RD_WAIT && mem_rvalid) begin
        r_data <= mem_rdata;
        r_resp <= err2resp(mem_err);
      end
    end
  end

endmodule
